// File: rtl/gnpu_pkg.sv
// Shared GNPU array geometry and the A-side feeder state encoding.
package gnpu_pkg;

    localparam int SA_ROWS           = 8;
    localparam int ELEM_W            = 8;
    localparam int SARRAY_LOAD_WIDTH = SA_ROWS * ELEM_W;
    localparam int TMMA_CNT_WIDTH    = 6;
    localparam int A_BUF_NUM         = 2;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_WAIT_BUF,
        FEED_ISSUE,
        FEED_DRAIN,
        FEED_RELEASE
    } feed_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth delay line carrying one lane's element plus its valid bit.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // NOTE: the data stages are reset along with the valids so a mid-tile reset leaves no stale element behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = vld[DEPTH-1] ? dat[DEPTH-1] : '0;

endmodule

// File: rtl/a_buf_feeder.sv
// Reads one ping-pong A buffer row by row and feeds it, diagonally skewed, into the systolic array.
module a_buf_feeder #(
    parameter int SA_ROWS = gnpu_pkg::SA_ROWS,
    parameter int ELEM_W  = gnpu_pkg::ELEM_W,
    parameter int LOAD_W  = SA_ROWS * ELEM_W,
    parameter int CNT_W   = gnpu_pkg::TMMA_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_buf_id_i,
    input  logic [CNT_W-1:0]                cmd_len_m1_i,
    input  logic [gnpu_pkg::A_BUF_NUM-1:0]  buf_full_i,
    output logic                            buf_release_o,
    output logic                            buf_release_id_o,
    output logic                            rd_a_buf_valid_o,
    output logic                            rd_a_buf_id_o,
    output logic [CNT_W-1:0]                rd_a_buf_addr_o,
    input  logic                            rd_a_buf_ret_valid_i,
    input  logic [LOAD_W-1:0]               rd_a_buf_ret_data_i,
    output logic [SA_ROWS-1:0]              sa_a_valid_o,
    output logic [LOAD_W-1:0]               sa_a_data_o,
    output logic                            busy_o
);

    import gnpu_pkg::*;

    localparam int DRAIN_W = $clog2(SA_ROWS + 1);

    feed_state_e        state;
    logic               buf_id;
    logic [CNT_W-1:0]   len_m1;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               cap_valid;
    logic [LOAD_W-1:0]  cap_data;

    assign rd_a_buf_id_o = buf_id;

    // The read address register doubles as the row counter.
    // NOTE: all state and outputs here use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FEED_IDLE;
            buf_id           <= 1'b0;
            len_m1           <= '0;
            drain_cnt        <= '0;
            cmd_ready_o      <= 1'b1;
            busy_o           <= 1'b0;
            buf_release_o    <= 1'b0;
            buf_release_id_o <= 1'b0;
            rd_a_buf_valid_o <= 1'b0;
            rd_a_buf_addr_o  <= '0;
        end else begin
            buf_release_o    <= 1'b0;
            buf_release_id_o <= 1'b0;
            case (state)
                FEED_IDLE: begin
                    if (cmd_valid_i) begin
                        buf_id      <= cmd_buf_id_i;
                        len_m1      <= cmd_len_m1_i;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= FEED_WAIT_BUF;
                    end
                end
                FEED_WAIT_BUF: begin
                    if (buf_full_i[buf_id]) begin
                        rd_a_buf_valid_o <= 1'b1;
                        rd_a_buf_addr_o  <= '0;
                        state            <= FEED_ISSUE;
                    end
                end
                FEED_ISSUE: begin
                    if (rd_a_buf_addr_o == len_m1) begin
                        rd_a_buf_valid_o <= 1'b0;
                        rd_a_buf_addr_o  <= '0;
                        drain_cnt        <= '0;
                        state            <= FEED_DRAIN;
                    end else begin
                        rd_a_buf_addr_o <= rd_a_buf_addr_o + CNT_W'(1);
                    end
                end
                FEED_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(SA_ROWS - 1)) begin
                        buf_release_o    <= 1'b1;
                        buf_release_id_o <= buf_id;
                        state            <= FEED_RELEASE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                FEED_RELEASE: begin
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= FEED_IDLE;
                end
                default: state <= FEED_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= rd_a_buf_valid_o && rd_a_buf_ret_valid_i;
            cap_data  <= (rd_a_buf_valid_o && rd_a_buf_ret_valid_i) ? rd_a_buf_ret_data_i : '0;
        end
    end

    // Lane 0 is fed straight from the capture register; lane r adds r more stages.
    for (genvar r = 0; r < SA_ROWS; r++) begin : g_lane
        if (r == 0) begin : g_direct
            assign sa_a_valid_o[0]          = cap_valid;
            assign sa_a_data_o[0 +: ELEM_W] = cap_data[0 +: ELEM_W];
        end else begin : g_skew
            sa_skew_line #(
                .DEPTH (r),
                .WIDTH (ELEM_W)
            ) u_skew (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (cap_valid),
                .in_data   (cap_data[r*ELEM_W +: ELEM_W]),
                .out_valid (sa_a_valid_o[r]),
                .out_data  (sa_a_data_o[r*ELEM_W +: ELEM_W])
            );
        end
    end

endmodule

// File: tb/tb_a_buf_feeder.sv
// Directed bench for a_buf_feeder with a 4-lane array and a behavioural a_buf.
module tb_a_buf_feeder;

    localparam int ROWS = 4;
    localparam int EW   = 8;
    localparam int LW   = ROWS * EW;
    localparam int CW   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_buf_id_i;
    logic [CW-1:0] cmd_len_m1_i;
    logic [1:0]    buf_full_i;
    logic          buf_release_o;
    logic          buf_release_id_o;
    logic          rd_a_buf_valid_o;
    logic          rd_a_buf_id_o;
    logic [CW-1:0] rd_a_buf_addr_o;
    logic          rd_a_buf_ret_valid_i;
    logic [LW-1:0] rd_a_buf_ret_data_i;
    logic [ROWS-1:0] sa_a_valid_o;
    logic [LW-1:0] sa_a_data_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int junk     = 0;

    typedef struct { int cyc; logic id; logic [CW-1:0] addr; } rd_t;
    typedef struct { int cyc; int lane; logic [EW-1:0] data; } ln_t;
    typedef struct { int cyc; logic id; } rel_t;

    rd_t  reads[$];
    ln_t  lanes[$];
    rel_t rels[$];

    a_buf_feeder #(
        .SA_ROWS (ROWS),
        .ELEM_W  (EW),
        .LOAD_W  (LW),
        .CNT_W   (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid_i          (cmd_valid_i),
        .cmd_ready_o          (cmd_ready_o),
        .cmd_buf_id_i         (cmd_buf_id_i),
        .cmd_len_m1_i         (cmd_len_m1_i),
        .buf_full_i           (buf_full_i),
        .buf_release_o        (buf_release_o),
        .buf_release_id_o     (buf_release_id_o),
        .rd_a_buf_valid_o     (rd_a_buf_valid_o),
        .rd_a_buf_id_o        (rd_a_buf_id_o),
        .rd_a_buf_addr_o      (rd_a_buf_addr_o),
        .rd_a_buf_ret_valid_i (rd_a_buf_ret_valid_i),
        .rd_a_buf_ret_data_i  (rd_a_buf_ret_data_i),
        .sa_a_valid_o         (sa_a_valid_o),
        .sa_a_data_o          (sa_a_data_o),
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Element e of row r in buffer b: row*0x10 + e, with buffer 1 offset by 0x80.
    function automatic logic [EW-1:0] elem(input logic id, input int row, input int lane);
        return EW'((row * 16 + lane + (id ? 128 : 0)) & 255);
    endfunction

    always_comb begin
        rd_a_buf_ret_valid_i = rd_a_buf_valid_o;
        rd_a_buf_ret_data_i  = '0;
        for (int l = 0; l < ROWS; l++)
            rd_a_buf_ret_data_i[l*EW +: EW] = elem(rd_a_buf_id_o, int'(rd_a_buf_addr_o), l);
    end

    always @(negedge clk) begin
        if (rd_a_buf_valid_o) reads.push_back('{cyc, rd_a_buf_id_o, rd_a_buf_addr_o});
        for (int r = 0; r < ROWS; r++) begin
            if (sa_a_valid_o[r]) lanes.push_back('{cyc, r, sa_a_data_o[r*EW +: EW]});
            else if (sa_a_data_o[r*EW +: EW] != '0) junk++;
        end
        if (buf_release_o) rels.push_back('{cyc, buf_release_id_o});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        reads.delete();
        lanes.delete();
        rels.delete();
        junk = 0;
    endtask

    task automatic send_cmd(input logic id, input logic [CW-1:0] len, output int c);
        int n = 0;
        step();
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL send_cmd ready_timeout got=%b exp=1", cmd_ready_o);
        end
        cmd_valid_i  = 1'b1;
        cmd_buf_id_i = id;
        cmd_len_m1_i = len;
        c = cyc;
        step();
        cmd_valid_i  = 1'b0;
    endtask

    task automatic wait_release(input int budget, input string name);
        int n = 0;
        while (rels.size() == 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (rels.size() == 0) begin
            failures++;
            $display("FAIL %s release_timeout got=none exp=pulse within %0d cycles", name, budget);
        end
    endtask

    // Reads at t0..t0+len, lane r row k at t0+k+1+r, release at t0+len+ROWS+1.
    task automatic expect_tile(input logic id, input int len, input int t0, input string name);
        int n;
        checks++;
        if (reads.size() != len + 1) begin
            failures++;
            $display("FAIL %s read_count got=%0d exp=%0d", name, reads.size(), len + 1);
        end
        for (int k = 0; k < reads.size() && k <= len; k++) begin
            checks++;
            if (reads[k].cyc !== t0 + k || reads[k].addr !== CW'(k) || reads[k].id !== id) begin
                failures++;
                $display("FAIL %s read%0d got=cyc%0d/id%0d/addr%0d exp=cyc%0d/id%0d/addr%0d",
                         name, k, reads[k].cyc, reads[k].id, reads[k].addr, t0 + k, id, k);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            n = 0;
            foreach (lanes[i]) begin
                if (lanes[i].lane == r) begin
                    checks++;
                    if (lanes[i].cyc !== t0 + n + 1 + r || lanes[i].data !== elem(id, n, r)) begin
                        failures++;
                        $display("FAIL %s lane%0d_row%0d got=cyc%0d/0x%02h exp=cyc%0d/0x%02h",
                                 name, r, n, lanes[i].cyc, lanes[i].data, t0 + n + 1 + r, elem(id, n, r));
                    end
                    n++;
                end
            end
            checks++;
            if (n != len + 1) begin
                failures++;
                $display("FAIL %s lane%0d_valid_count got=%0d exp=%0d", name, r, n, len + 1);
            end
        end
        checks++;
        if (rels.size() != 1) begin
            failures++;
            $display("FAIL %s release_count got=%0d exp=1", name, rels.size());
        end else begin
            checks++;
            if (rels[0].cyc !== t0 + len + ROWS + 1 || rels[0].id !== id) begin
                failures++;
                $display("FAIL %s release got=cyc%0d/id%0d exp=cyc%0d/id%0d",
                         name, rels[0].cyc, rels[0].id, t0 + len + ROWS + 1, id);
            end
        end
        checks++;
        if (junk != 0) begin
            failures++;
            $display("FAIL %s invalid_lane_nonzero got=%0d exp=0", name, junk);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_buf_id_i = 1'b0;
        cmd_len_m1_i = '0;
        buf_full_i   = 2'b00;
        step();
        step();
        checks++;
        if ({cmd_ready_o, busy_o, rd_a_buf_valid_o, buf_release_o} !== 4'b1000) begin
            failures++;
            $display("FAIL reset ready_busy_rd_rel got=%b exp=1000",
                     {cmd_ready_o, busy_o, rd_a_buf_valid_o, buf_release_o});
        end
        checks++;
        if (sa_a_valid_o !== '0 || sa_a_data_o !== '0 || rd_a_buf_addr_o !== '0) begin
            failures++;
            $display("FAIL reset lanes_addr got=%b/0x%08h/%0d exp=0/0/0",
                     sa_a_valid_o, sa_a_data_o, rd_a_buf_addr_o);
        end
        rst_n = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic test_basic();
        int c;
        clear_logs();
        buf_full_i = 2'b01;
        send_cmd(1'b0, 6'd3, c);
        wait_release(100, "basic");
        expect_tile(1'b0, 3, c + 2, "basic");
    endtask

    task automatic test_buffer_wait();
        int c;
        int f;
        clear_logs();
        buf_full_i = 2'b00;
        send_cmd(1'b1, 6'd3, c);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (reads.size() != 0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL buffer_wait early_read got=%0d/busy%b exp=0/busy1", reads.size(), busy_o);
        end
        buf_full_i = 2'b10;
        f = cyc;
        wait_release(100, "buffer_wait");
        expect_tile(1'b1, 3, f + 1, "buffer_wait");
    endtask

    task automatic test_single_row();
        int c;
        clear_logs();
        buf_full_i = 2'b01;
        send_cmd(1'b0, 6'd0, c);
        wait_release(100, "single_row");
        expect_tile(1'b0, 0, c + 2, "single_row");
    endtask

    task automatic test_full_tile();
        int c;
        clear_logs();
        buf_full_i = 2'b10;
        send_cmd(1'b1, 6'd63, c);
        wait_release(200, "full_tile");
        expect_tile(1'b1, 63, c + 2, "full_tile");
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        int rel0;
        clear_logs();
        buf_full_i = 2'b11;
        send_cmd(1'b0, 6'd3, c0);
        wait_release(100, "pingpong0");
        expect_tile(1'b0, 3, c0 + 2, "pingpong0");
        rel0 = c0 + 2 + 3 + ROWS + 1;
        clear_logs();
        send_cmd(1'b1, 6'd2, c1);
        checks++;
        if (c1 !== rel0 + 1) begin
            failures++;
            $display("FAIL pingpong accept_cycle got=%0d exp=%0d", c1, rel0 + 1);
        end
        wait_release(100, "pingpong1");
        expect_tile(1'b1, 2, rel0 + 3, "pingpong1");
    endtask

    task automatic test_ignore_busy();
        int c;
        clear_logs();
        buf_full_i = 2'b11;
        send_cmd(1'b0, 6'd2, c);
        cmd_valid_i  = 1'b1;
        cmd_buf_id_i = 1'b1;
        cmd_len_m1_i = 6'd5;
        step();
        checks++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL ignore_busy ready_busy got=%b%b exp=01", cmd_ready_o, busy_o);
        end
        step();
        step();
        cmd_valid_i = 1'b0;
        wait_release(100, "ignore_busy");
        expect_tile(1'b0, 2, c + 2, "ignore_busy");
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (reads.size() != 3 || rels.size() != 1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy extra_tile got=reads%0d/rels%0d/busy%b exp=reads3/rels1/busy0",
                     reads.size(), rels.size(), busy_o);
        end
    endtask

    task automatic test_reset_mid_issue();
        int c;
        int t0;
        clear_logs();
        buf_full_i = 2'b01;
        send_cmd(1'b0, 6'd7, c);
        t0 = c + 2;
        while (cyc < t0 + 2) step();
        checks++;
        if (sa_a_valid_o !== 4'b0011 || rd_a_buf_addr_o !== 6'd2) begin
            failures++;
            $display("FAIL reset_mid pre_reset got=valid%b/addr%0d exp=valid0011/addr2",
                     sa_a_valid_o, rd_a_buf_addr_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sa_a_valid_o !== '0 || sa_a_data_o !== '0 || rd_a_buf_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid async_clear got=valid%b/0x%08h/rd%b exp=0/0/0",
                     sa_a_valid_o, sa_a_data_o, rd_a_buf_valid_o);
        end
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid ready_busy got=%b%b exp=10", cmd_ready_o, busy_o);
        end
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (rels.size() != 0 || reads.size() != 0 || lanes.size() != 0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid after got=rels%0d/reads%0d/lanes%0d/ready%b exp=0/0/0/1",
                     rels.size(), reads.size(), lanes.size(), cmd_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_buffer_wait();
        test_single_row();
        test_full_tile();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
